// File: rtl/ram_sdp_param_if.sv
// Bus bundle for the simple dual-port RAM: one write port, one read port and
// the init status. Clock and reset stay outside as plain ports.
interface ram_sdp_param_if #(
  parameter int DW = 64,
  parameter int AW = 4
) ();
  logic            wr;
  logic [AW-1:0]   wr_addr;
  logic [DW/8-1:0] wr_be;
  logic [DW-1:0]   wr_data;
  logic            rd;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            init_busy;

  // Strobes are single-cycle requests accepted only while init_busy is low;
  // there is no backpressure, and rd_valid pulses once per accepted read.
  modport master (
    output wr, wr_addr, wr_be, wr_data, rd, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr, wr_addr, wr_be, wr_data, rd, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/ram_sdp_param.sv
// Simple dual-port RAM with byte enables, optional output register, optional
// write-first forwarding and a post-reset zero-fill sequencer.
module ram_sdp_param #(
  parameter int DW       = 64,
  parameter int AW       = 4,
  parameter int OUT_REG  = 0,
  parameter int BYPASS   = 0,
  parameter int INIT_CLR = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ram_sdp_param_if.slave bus,
  output logic [1:0]     o_dbg_state
);
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  logic [DW-1:0] r_mem [DEPTH];

  logic          w_clr_we;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic          w_collide;
  logic [DW-1:0] w_mem_rd;
  logic [DW-1:0] w_fwd;

  logic [DW-1:0] r_s1_data;
  logic          r_s1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (INIT_CLR != 0) begin
            r_state <= ST_CLEAR;
          end else begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          // The counter rolls back to zero on the same edge the state exits.
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {AW{1'b1}}) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_READY: r_state <= ST_READY;
        default: begin
          r_state <= ST_RESET;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign w_clr_we  = rst_n && (r_state == ST_CLEAR);
  assign w_wr_acc  = rst_n && (r_state == ST_READY) && bus.wr;
  assign w_rd_acc  = rst_n && (r_state == ST_READY) && bus.rd;
  assign w_collide = w_wr_acc && (bus.wr_addr == bus.rd_addr);
  assign w_mem_rd  = r_mem[bus.rd_addr];

  // Forwarded word mirrors exactly what the write port commits this edge.
  always_comb begin
    w_fwd = w_mem_rd;
    if ((BYPASS != 0) && w_collide) begin
      for (int i = 0; i < BW; i++) begin
        if (bus.wr_be[i]) w_fwd[8*i +: 8] = bus.wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int i = 0; i < BW; i++) begin
        if (bus.wr_be[i]) r_mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_data  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) r_s1_data <= w_fwd;
    end
  end

  if (OUT_REG != 0) begin : gen_out_reg
    logic [DW-1:0] r_s2_data;
    logic          r_s2_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_s2_data  <= '0;
        r_s2_valid <= 1'b0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_s2_data <= r_s1_data;
      end
    end

    assign bus.rd_data  = r_s2_data;
    assign bus.rd_valid = r_s2_valid;
  end else begin : gen_no_out_reg
    assign bus.rd_data  = r_s1_data;
    assign bus.rd_valid = r_s1_valid;
  end

  assign bus.init_busy = r_busy;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_ram_sdp_param.sv
// Bench for ram_sdp_param: two instances (plain/read-old and registered/forwarding)
// driven in lockstep and checked against a memory model through expected queues.
module tb_ram_sdp_param;
  localparam int DW    = 64;
  localparam int AW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_sdp_param_if #(.DW(DW), .AW(AW)) if0 ();
  ram_sdp_param_if #(.DW(DW), .AW(AW)) if1 ();
  logic [1:0] st0;
  logic [1:0] st1;

  ram_sdp_param #(.DW(DW), .AW(AW), .OUT_REG(0), .BYPASS(0), .INIT_CLR(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .o_dbg_state(st0)
  );
  ram_sdp_param #(.DW(DW), .AW(AW), .OUT_REG(1), .BYPASS(1), .INIT_CLR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave), .o_dbg_state(st1)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            cyc_q0[$];
  int            cyc_q1[$];
  logic [DW-1:0] model [DEPTH];
  bit            model_live = 1'b0;
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;
  logic [DW-1:0] pop_d0, pop_d1;
  int            pop_c0, pop_c1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%h expected=0x%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (if0.rd_valid === 1'b1) begin
      if (exp_q0.size() == 0) check_eq("dut0_unexpected_valid", if0.rd_valid, 0);
      else begin
        pop_d0 = exp_q0.pop_front();
        pop_c0 = cyc_q0.pop_front();
        check_eq("dut0_rd_data", if0.rd_data, pop_d0);
        check_eq("dut0_rd_cycle", cyc, pop_c0);
        last0 = pop_d0;
      end
    end
    if (if1.rd_valid === 1'b1) begin
      if (exp_q1.size() == 0) check_eq("dut1_unexpected_valid", if1.rd_valid, 0);
      else begin
        pop_d1 = exp_q1.pop_front();
        pop_c1 = cyc_q1.pop_front();
        check_eq("dut1_rd_data", if1.rd_data, pop_d1);
        check_eq("dut1_rd_cycle", cyc, pop_c1);
        last1 = pop_d1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_bus(input bit w, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                         input logic [DW-1:0] wd, input bit r, input logic [AW-1:0] ra);
    if0.wr = w; if0.wr_addr = wa; if0.wr_be = be; if0.wr_data = wd; if0.rd = r; if0.rd_addr = ra;
    if1.wr = w; if1.wr_addr = wa; if1.wr_be = be; if1.wr_data = wd; if1.rd = r; if1.rd_addr = ra;
  endtask

  task automatic drive(input bit w, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd, input bit r, input logic [AW-1:0] ra);
    logic [DW-1:0] old;
    set_bus(w, wa, be, wd, r, ra);
    if (model_live) begin
      if (r) begin
        old = model[ra];
        exp_q0.push_back(old);
        cyc_q0.push_back(cyc + 1);
        exp_q1.push_back((w && wa == ra) ? merge(old, wd, be) : old);
        cyc_q1.push_back(cyc + 2);
      end
      if (w) model[wa] = merge(model[wa], wd, be);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic drive_junk();
    drive(1'b1, AW'($urandom_range(0, DEPTH - 1)), '1, {$urandom, $urandom} | 64'h1,
          1'b1, AW'($urandom_range(0, DEPTH - 1)));
  endtask

  task automatic do_reset(input string tag, input int n);
    model_live = 1'b0;
    rst_n = 1'b0;
    set_bus(1'b0, '0, '0, '0, 1'b0, '0);
    repeat (n) @(negedge clk);
    exp_q0.delete(); cyc_q0.delete();
    exp_q1.delete(); cyc_q1.delete();
    check_eq({tag, "_rd_data0"}, if0.rd_data, 0);
    check_eq({tag, "_rd_data1"}, if1.rd_data, 0);
    check_eq({tag, "_rd_valid1"}, if1.rd_valid, 0);
    check_eq({tag, "_busy0"}, if0.init_busy, 1);
    check_eq({tag, "_state0"}, st0, 0);
    check_eq({tag, "_state1"}, st1, 0);
  endtask

  // Counts cycles with init_busy high after release while junk traffic is offered.
  task automatic wait_init(input string tag);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40; k++) begin
      drive_junk();
      if (if0.init_busy) n0++;
      if (if1.init_busy) n1++;
      if (!if0.init_busy && !if1.init_busy) break;
    end
    set_bus(1'b0, '0, '0, '0, 1'b0, '0);
    check_eq({tag, "_busy_cycles0"}, n0, 16);
    check_eq({tag, "_busy_cycles1"}, n1, 16);
    check_eq({tag, "_ready_state0"}, st0, 2);
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    model_live = 1'b1;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
    idle(4);
  endtask

  task automatic random_traffic(input int n);
    for (int k = 0; k < n; k++)
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), BW'($urandom),
            {$urandom, $urandom}, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)));
    idle(4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    set_bus(1'b0, '0, '0, '0, 1'b0, '0);
    @(negedge clk);
    do_reset("rst", 3);
    rst_n = 1'b1;
    wait_init("init");
    read_all();

    // Full write then lower-half byte-enable overwrite.
    drive(1'b1, 4'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, '0);
    drive(1'b1, 4'd3, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd3);
    drive(1'b1, 4'd4, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 4'd4);
    idle(3);

    // Same-address collisions: full and partial byte enables.
    drive(1'b1, 4'd5, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, '0);
    drive(1'b1, 4'd5, 8'hFF, 64'h5555_5555_5555_5555, 1'b1, 4'd5);
    drive(1'b1, 4'd5, 8'h0F, 64'h1234_5678_9ABC_DEF0, 1'b1, 4'd5);
    drive(1'b1, 4'd6, 8'hFF, 64'h6666_6666_6666_6666, 1'b1, 4'd5);
    idle(3);

    // Back-to-back reads of distinct words, latency tracked per read.
    for (int a = 0; a < 4; a++)
      drive(1'b1, AW'(a), 8'hFF, {32'hC0DE_0000 + a, 32'h0BAD_F00D ^ a}, 1'b0, '0);
    for (int a = 0; a < 4; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a));
    idle(4);

    // Output holds across idle cycles and later writes to the same address.
    drive(1'b1, 4'd3, 8'hFF, 64'hFEED_FACE_CAFE_BABE, 1'b0, '0);
    drive(1'b1, 4'd2, 8'hFF, 64'h1111_2222_3333_4444, 1'b0, '0);
    idle(2);
    check_eq("hold_rd_data0", if0.rd_data, last0);
    check_eq("hold_rd_data1", if1.rd_data, last1);

    random_traffic(150);
    read_all();

    // Reset with a read in flight, then abort the clear at counter 9.
    drive(1'b0, '0, '0, '0, 1'b1, 4'd0);
    do_reset("midread", 2);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) drive_junk();
    check_eq("abort_state0", st0, 1);
    rst_n = 1'b0;
    drive_junk();
    rst_n = 1'b1;
    wait_init("abort");
    read_all();

    random_traffic(100);
    read_all();
    check_eq("drain_q0", exp_q0.size(), 0);
    check_eq("drain_q1", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end
endmodule
